// File: rtl/fpu_req_arbiter_pkg.sv
// Shared FPU definitions: operand/result widths, opcode set, opcode legality check
// and the request-arbiter state encoding.
package fpu_package;

    localparam int INPUT_WIDTH  = 16;
    localparam int OUTPUT_WIDTH = 32;

    typedef enum logic [3:0] {
        LOGIC_SHIFT = 4'd0,
        ARITH_SHIFT = 4'd1,
        CIRC_SHIFT  = 4'd2,
        LZD         = 4'd3,
        BARREL      = 4'd4,
        REV         = 4'd5,
        ADD         = 4'd6,
        SUB         = 4'd7,
        MUL         = 4'd8,
        DIV         = 4'd9
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    function automatic logic is_legal_op(input logic [3:0] sel);
        case (sel)
            LOGIC_SHIFT, ARITH_SHIFT, CIRC_SHIFT, LZD, BARREL,
            REV, ADD, SUB, MUL, DIV: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_req_arbiter_rr.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
// Shared by the controllers that front a single shared resource.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any_valid
);

    logic            found_s;
    logic [ID_W-1:0] idx_s;

    // Walk the ring from ptr+1 and keep only the first hit.
    always_comb begin
        grant   = '0;
        id      = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                found_s      = 1'b1;
                grant[idx_s] = 1'b1;
                id           = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/fpu_req_arbiter.sv
// Round-robin front end sharing one FPU between NUM_REQ requesters, one op in flight.
// Define FPU_ARB_TIMEOUT_EN to add a WAIT-state watchdog that errors out after TIMEOUT_CYCLES.
module fpu_req_arbiter
    import fpu_package::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*4-1:0]            req_sel,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]  req_in1,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0]  req_in2,
    input  logic [NUM_REQ-1:0]              req_in3,
    output logic                            fpu_start,
    output logic [3:0]                      fpu_sel,
    output logic [INPUT_WIDTH-1:0]          fpu_in1,
    output logic [INPUT_WIDTH-1:0]          fpu_in2,
    output logic                            fpu_in3,
    input  logic                            fpu_done,
    input  logic [OUTPUT_WIDTH-1:0]         fpu_out,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [OUTPUT_WIDTH-1:0]         rsp_data,
    output logic                            rsp_err
);

    arb_state_e              state_r;
    arb_state_e              state_next_s;
    logic [ID_W-1:0]         rr_ptr_r;
    logic [ID_W-1:0]         id_r;

    logic [NUM_REQ-1:0]      grant_s;
    logic [ID_W-1:0]         grant_id_s;
    logic                    any_s;
    logic [3:0]              grant_sel_s;
    logic [INPUT_WIDTH-1:0]  grant_in1_s;
    logic [INPUT_WIDTH-1:0]  grant_in2_s;
    logic                    grant_in3_s;
    logic                    grant_legal_s;
    logic                    timeout_s;

    logic                    fpu_start_r;
    logic [3:0]              fpu_sel_r;
    logic [INPUT_WIDTH-1:0]  fpu_in1_r;
    logic [INPUT_WIDTH-1:0]  fpu_in2_r;
    logic                    fpu_in3_r;
    logic                    rsp_valid_r;
    logic [OUTPUT_WIDTH-1:0] rsp_data_r;
    logic                    rsp_err_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .id        (grant_id_s),
        .any_valid (any_s)
    );

    // One-hot AND-OR mux of the granted requester's opcode and operands.
    always_comb begin
        grant_sel_s = 4'd0;
        grant_in1_s = '0;
        grant_in2_s = '0;
        grant_in3_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_sel_s = grant_sel_s | (req_sel[i*4 +: 4] & {4{grant_s[i]}});
            grant_in1_s = grant_in1_s | (req_in1[i*INPUT_WIDTH +: INPUT_WIDTH] & {INPUT_WIDTH{grant_s[i]}});
            grant_in2_s = grant_in2_s | (req_in2[i*INPUT_WIDTH +: INPUT_WIDTH] & {INPUT_WIDTH{grant_s[i]}});
            grant_in3_s = grant_in3_s | (req_in3[i] & grant_s[i]);
        end
    end

    assign grant_legal_s = is_legal_op(grant_sel_s);

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_r;

    // Watchdog count of cycles spent in WAIT; restarts on every launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (state_r == ISSUE) begin
            wait_cnt_r <= '0;
        end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign timeout_s = (state_r == WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Grant is only offered while idle and out of reset.
    always_comb begin
        if (!reset && (state_r == IDLE)) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state logic; illegal opcodes bypass the FPU entirely.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    if (grant_legal_s) begin
                        state_next_s = ISSUE;
                    end else begin
                        state_next_s = RESP;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: state_next_s = WAIT;
            WAIT: begin
                if (fpu_done || timeout_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: latch the granted request, launch the FPU, capture the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r    <= ID_W'(NUM_REQ - 1);
            id_r        <= '0;
            fpu_start_r <= 1'b0;
            fpu_sel_r   <= 4'd0;
            fpu_in1_r   <= '0;
            fpu_in2_r   <= '0;
            fpu_in3_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            fpu_start_r <= (state_next_s == ISSUE);
            rsp_valid_r <= (state_next_s == RESP);
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        id_r     <= grant_id_s;
                        rr_ptr_r <= grant_id_s;
                        if (grant_legal_s) begin
                            fpu_sel_r <= grant_sel_s;
                            fpu_in1_r <= grant_in1_s;
                            fpu_in2_r <= grant_in2_s;
                            fpu_in3_r <= grant_in3_s;
                        end else begin
                            rsp_data_r <= '0;
                            rsp_err_r  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (fpu_done) begin
                        rsp_data_r <= fpu_out;
                        rsp_err_r  <= 1'b0;
                    end else if (timeout_s) begin
                        rsp_data_r <= '0;
                        rsp_err_r  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fpu_start = fpu_start_r;
    assign fpu_sel   = fpu_sel_r;
    assign fpu_in1   = fpu_in1_r;
    assign fpu_in2   = fpu_in2_r;
    assign fpu_in3   = fpu_in3_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = id_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Scoreboard bench for fpu_req_arbiter with a behavioural FPU of configurable latency.
module tb_fpu_req_arbiter;
    import fpu_package::*;

    localparam int NR = 4;
    localparam int IW = INPUT_WIDTH;
    localparam int OW = OUTPUT_WIDTH;
    localparam int TO = 64;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*4-1:0]   req_sel;
    logic [NR*IW-1:0]  req_in1;
    logic [NR*IW-1:0]  req_in2;
    logic [NR-1:0]     req_in3;
    logic              fpu_start;
    logic [3:0]        fpu_sel;
    logic [IW-1:0]     fpu_in1;
    logic [IW-1:0]     fpu_in2;
    logic              fpu_in3;
    logic              fpu_done;
    logic [OW-1:0]     fpu_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [OW-1:0]     rsp_data;
    logic              rsp_err;

    fpu_req_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_in1(req_in1), .req_in2(req_in2), .req_in3(req_in3),
        .fpu_start(fpu_start), .fpu_sel(fpu_sel), .fpu_in1(fpu_in1),
        .fpu_in2(fpu_in2), .fpu_in3(fpu_in3), .fpu_done(fpu_done), .fpu_out(fpu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    id;
        logic [OW-1:0] data;
        logic          err;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          fpu_lat = 1;
    bit          fpu_hang = 1'b0;
    int          manual_req = 0;
    int          manual_seen = 0;
    logic [OW-1:0] model_res;

    function automatic logic [OW-1:0] fpu_ref(input logic [3:0] s, input logic [IW-1:0] a, input logic [IW-1:0] b);
        case (s)
            ADD:     return OW'(a) + OW'(b);
            SUB:     return OW'(a) - OW'(b);
            MUL:     return OW'(a) * OW'(b);
            default: return OW'(a) ^ OW'(b);
        endcase
    endfunction

    // Behavioural FPU: responds fpu_lat cycles after a start pulse, or on a manual request.
    initial begin
        fpu_done = 1'b0;
        fpu_out  = '0;
        forever begin
            @(negedge clk);
            if (manual_req != manual_seen) begin
                manual_seen = manual_req;
                fpu_done = 1'b1; fpu_out = 32'hDEAD_BEEF;
                @(negedge clk);
                fpu_done = 1'b0; fpu_out = '0;
            end else if (fpu_start === 1'b1 && !fpu_hang) begin
                model_res = fpu_ref(fpu_sel, fpu_in1, fpu_in2);
                repeat (fpu_lat) @(negedge clk);
                fpu_done = 1'b1; fpu_out = model_res;
                @(negedge clk);
                fpu_done = 1'b0; fpu_out = '0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] s, input logic [IW-1:0] a, input logic [IW-1:0] b, input logic f);
        req_sel[i*4 +: 4]   = s;
        req_in1[i*IW +: IW] = a;
        req_in2[i*IW +: IW] = b;
        req_in3[i]          = f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        #1;
    endtask

    task automatic wait_grant(input int budget, output logic [NR-1:0] g);
        g = '0;
        #1;
        for (int i = 0; i < budget; i++) begin
            if (req_ready !== '0) begin
                g = req_ready;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        req_sel = '0; req_in1 = '0; req_in2 = '0; req_in3 = '0;
        repeat (3) tick();
        total++;
        if ({fpu_start, fpu_sel, fpu_in1, fpu_in2, fpu_in3} !== '0) begin
            bad++; $display("FAIL reset_fpu_side: got %h want 0", {fpu_start, fpu_sel, fpu_in1, fpu_in2, fpu_in3});
        end
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin
            bad++; $display("FAIL reset_rsp_side: got %h want 0", {rsp_valid, rsp_id, rsp_data, rsp_err});
        end
        req_valid = '1;
        tick();
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
        end
        req_valid = '0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        exp_t e;
        fpu_lat = 1; fpu_hang = 1'b0;
        set_req(0, ADD, 16'h0003, 16'h0004, 1'b1);
        req_valid = 4'b0001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        sb_q.push_back('{id: 2'd0, data: 32'd7, err: 1'b0});
        tick(); req_valid = '0;
        total++;
        if ({fpu_start, fpu_sel, fpu_in1, fpu_in2, fpu_in3} !== {1'b1, 4'd6, 16'h0003, 16'h0004, 1'b1}) begin
            bad++; $display("FAIL single_issue: got %h want %h", {fpu_start, fpu_sel, fpu_in1, fpu_in2, fpu_in3},
                            {1'b1, 4'd6, 16'h0003, 16'h0004, 1'b1});
        end
        tick();
        total++;
        if ({rsp_valid, fpu_start} !== 2'b00) begin
            bad++; $display("FAIL single_wait: got rsp_valid,fpu_start=%b want 00", {rsp_valid, fpu_start});
        end
        tick();
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++; $display("FAIL single_latency: rsp_valid got %b want 1 at T+3", rsp_valid);
        end
        e = sb_q.pop_front();
        total++;
        if ({rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
            bad++; $display("FAIL single_rsp: got %h/%h/%b want %h/%h/%b", rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_rsp_drop: rsp_valid got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] g;
        logic [NR-1:0] want;
        bit ok;
        exp_t e;
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, ADD, IW'(i), 16'h0000, 1'b0);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(20, g);
            want = NR'(1) << (k % NR);
            total++;
            if (g !== want) begin
                bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, g, want);
            end
            sb_q.push_back('{id: 2'(k % NR), data: OW'(k % NR), err: 1'b0});
            tick();
            wait_rsp(20, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL rr_rsp_timeout[%0d]: rsp_valid got 0 want 1", k);
            end
            e = sb_q.pop_front();
            total++;
            if ({rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
                bad++; $display("FAIL rr_rsp[%0d]: got %h/%h/%b want %h/%h/%b", k, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [NR-1:0] g;
        bit ok;
        exp_t e;
        set_req(1, MUL, 16'h0012, 16'h0034, 1'b0);
        set_req(3, ADD, 16'h0005, 16'h0006, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        wait_grant(20, g);
        total++;
        if (g !== 4'b0010) begin
            bad++; $display("FAIL bp_grant: got %b want 0010", g);
        end
        sb_q.push_back('{id: 2'd1, data: 32'h0000_03A8, err: 1'b0});
        tick(); req_valid = 4'b1000;
        wait_rsp(20, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL bp_rsp_timeout: rsp_valid got 0 want 1");
        end
        e = sb_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err, req_ready} !== {1'b1, e.id, e.data, e.err, 4'b0000}) begin
                bad++; $display("FAIL bp_hold[%0d]: got %b/%h/%h/%b/%b want 1/%h/%h/%b/0000", c,
                                rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, e.id, e.data, e.err);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        total++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b1000}) begin
            bad++; $display("FAIL bp_release: rsp_valid,req_ready got %b want 0_1000", {rsp_valid, req_ready});
        end
        sb_q.push_back('{id: 2'd3, data: 32'd11, err: 1'b0});
        tick(); req_valid = '0;
        wait_rsp(20, ok);
        e = sb_q.pop_front();
        total++;
        if (!ok || {rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
            bad++; $display("FAIL bp_next_rsp: got v=%b %h/%h/%b want %h/%h/%b", ok, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [NR-1:0] g;
        exp_t e;
        int starts = 0;
        bit seen = 1'b0;
        set_req(2, 4'hF, 16'h1234, 16'h5678, 1'b1);
        req_valid = 4'b0100;
        wait_grant(20, g);
        total++;
        if (g !== 4'b0100) begin
            bad++; $display("FAIL illegal_grant: got %b want 0100", g);
        end
        sb_q.push_back('{id: 2'd2, data: 32'd0, err: 1'b1});
        tick(); req_valid = '0;
        for (int n = 0; n < 8; n++) begin
            if (fpu_start === 1'b1) starts++;
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        e = sb_q.pop_front();
        total++;
        if (!seen || {rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
            bad++; $display("FAIL illegal_rsp: got v=%b %h/%h/%b want %h/%h/%b", seen, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
        end
        tick();
        if (fpu_start === 1'b1) starts++;
        total++;
        if (starts !== 0) begin
            bad++; $display("FAIL illegal_no_start: fpu_start pulses got %0d want 0", starts);
        end
    endtask

    task automatic test_latency();
        logic [NR-1:0] g;
        exp_t e;
        fpu_lat = 5;
        set_req(3, SUB, 16'd100, 16'd1, 1'b0);
        req_valid = 4'b1000;
        wait_grant(20, g);
        total++;
        if (g !== 4'b1000) begin
            bad++; $display("FAIL lat_grant: got %b want 1000", g);
        end
        sb_q.push_back('{id: 2'd3, data: 32'd99, err: 1'b0});
        tick(); req_valid = '0;
        total++;
        if (fpu_start !== 1'b1) begin
            bad++; $display("FAIL lat_start: fpu_start got %b want 1", fpu_start);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) begin
                total++;
                if ({fpu_start, fpu_sel, fpu_in1, fpu_in2} !== {1'b0, 4'd7, 16'd100, 16'd1}) begin
                    bad++; $display("FAIL lat_hold: got %h want %h", {fpu_start, fpu_sel, fpu_in1, fpu_in2}, {1'b0, 4'd7, 16'd100, 16'd1});
                end
            end
        end
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL lat_early: rsp_valid got %b want 0 at T+6", rsp_valid);
        end
        tick();
        e = sb_q.pop_front();
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
            bad++; $display("FAIL lat_rsp: got %b/%h/%h/%b want 1/%h/%h/%b", rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
        end
        tick();
        fpu_lat = 1;
    endtask

    task automatic test_reset_mid_wait();
        logic [NR-1:0] g;
        bit ok;
        exp_t e;
        int spurious = 0;
        fpu_hang = 1'b1;
        set_req(0, MUL, 16'd7, 16'd9, 1'b1);
        req_valid = 4'b0001;
        wait_grant(20, g);
        tick(); req_valid = '0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        total++;
        if ({fpu_start, fpu_sel, fpu_in1, fpu_in2, fpu_in3, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready} !== '0) begin
            bad++; $display("FAIL rstwait_outputs: got %h want 0",
                            {fpu_start, fpu_sel, fpu_in1, fpu_in2, fpu_in3, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready});
        end
        manual_req++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || fpu_start !== 1'b0) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++; $display("FAIL rstwait_late_done: spurious cycles got %0d want 0", spurious);
        end
        fpu_hang = 1'b0;
        set_req(0, ADD, 16'd1, 16'd1, 1'b0);
        set_req(1, ADD, 16'd2, 16'd2, 1'b0);
        req_valid = 4'b0011;
        wait_grant(20, g);
        total++;
        if (g !== 4'b0001) begin
            bad++; $display("FAIL rstwait_ptr: grant got %b want 0001", g);
        end
        sb_q.push_back('{id: 2'd0, data: 32'd2, err: 1'b0});
        tick(); req_valid = '0;
        wait_rsp(20, ok);
        e = sb_q.pop_front();
        total++;
        if (!ok || {rsp_id, rsp_data, rsp_err} !== {e.id, e.data, e.err}) begin
            bad++; $display("FAIL rstwait_next_rsp: got v=%b %h/%h/%b want %h/%h/%b", ok, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
        end
        tick();
    endtask

`ifdef FPU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [NR-1:0] g;
        exp_t e;
        int spurious = 0;
        fpu_hang = 1'b1;
        set_req(1, ADD, 16'd3, 16'd3, 1'b0);
        req_valid = 4'b0010;
        wait_grant(20, g);
        total++;
        if (g !== 4'b0010) begin
            bad++; $display("FAIL timeout_grant: got %b want 0010", g);
        end
        sb_q.push_back('{id: 2'd1, data: 32'd0, err: 1'b1});
        tick(); req_valid = '0;
        repeat (TO) tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_early: rsp_valid got %b want 0", rsp_valid);
        end
        tick();
        e = sb_q.pop_front();
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, e.id, e.data, e.err}) begin
            bad++; $display("FAIL timeout_rsp: got %b/%h/%h/%b want 1/%h/%h/%b", rsp_valid, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
        end
        tick();
        manual_req++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0) spurious++;
        end
        total++;
        if (spurious !== 0) begin
            bad++; $display("FAIL timeout_late_done: spurious cycles got %0d want 0", spurious);
        end
        fpu_hang = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_latency();
        test_reset_mid_wait();
`ifdef FPU_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
